sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have no parameters; widths are fixed (address 20, data 16).
REQ-002 i_clk  input  1  system clock, 12 MHz audio domain.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_wr_req  input  1  write request (recorder), level, held until o_wr_ack.
REQ-005 i_wr_addr  input  20  write word address, stable while i_wr_req high.
REQ-006 i_wr_data  input  16  write data, stable while i_wr_req high.
REQ-007 o_wr_ack  output  1  one-cycle pulse, write completed.
REQ-008 i_rd_req  input  1  read request (player/DSP), level, held until o_rd_valid.
REQ-009 i_rd_addr  input  20  read word address, stable while i_rd_req high.
REQ-010 o_rd_valid  output  1  one-cycle pulse, o_rd_data valid.
REQ-011 o_rd_data  output  16  read data, holds value until next read completes.
REQ-012 o_busy  output  1  high whenever state is not IDLE.
REQ-013 o_SRAM_ADDR  output  20; io_SRAM_DQ  inout  16; o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N  output  1 each, active-low SRAM controls.

Function
REQ-014 States SHALL be IDLE, WR1, WR2, RD1, RD2; all outputs registered.
REQ-015 IDLE: requests sampled only here; none pending -> stay IDLE.
REQ-016 Only one request -> grant it: write -> WR1, read -> RD1; address/data latched at the granting edge.
REQ-017 Both requests -> grant the requester not granted last (round-robin flag); flag reset value selects write first.
REQ-018 WR1: CE_N=0, WE_N=0, OE_N=1, LB_N=UB_N=0, DQ driven with latched data; next WR2.
REQ-019 WR2: WE_N=1, CE_N=0, DQ still driven (hold), o_wr_ack=1; next IDLE.
REQ-020 RD1: CE_N=0, OE_N=0, WE_N=1, LB_N=UB_N=0, DQ high-Z; next RD2.
REQ-021 RD2: controls as RD1; o_rd_data captures io_SRAM_DQ at the RD2->IDLE edge; o_rd_valid=1 in the cycle after that edge (one cycle).
REQ-022 IDLE outputs: CE_N=OE_N=WE_N=LB_N=UB_N=1, DQ high-Z, o_SRAM_ADDR holds last value.
REQ-023 Latency: write request seen in IDLE -> o_wr_ack 2 cycles later; read -> o_rd_valid 3 cycles later; minimum 3 cycles per access.
REQ-024 Requester drops req on the edge it sees ack/valid; a req still high in IDLE is a new request.
REQ-025 Req deassertion mid-access SHALL NOT abort the access; ack/valid still issued.
REQ-026 DQ SHALL never be driven while OE_N=0; WE_N and OE_N never both 0.
REQ-027 Address values 0x00000 and 0xFFFFF SHALL pass unmodified (no wrap logic inside block).

Reset
REQ-028 On i_rst_n=0, immediately: state IDLE, o_wr_ack=0, o_rd_valid=0, o_rd_data=0, o_busy=0, o_SRAM_ADDR=0, all SRAM controls 1, DQ high-Z, round-robin flag = write-next.
REQ-029 Reset mid-access SHALL abandon the access with no ack/valid; first post-reset grant follows REQ-017.

Verification
REQ-030 Single write addr 0x00010 data 0xA5A5 -> WR1 shows WE_N=0, DQ=0xA5A5, ADDR=0x00010; o_wr_ack 2 cycles after grant.
REQ-031 Read addr 0x00010 with SRAM model holding 0xA5A5 -> OE_N=0 two cycles, o_rd_data=0xA5A5, o_rd_valid 3 cycles after grant.
REQ-032 Both req high continuously from reset -> grants alternate W,R,W,R; each ack/valid pulse exactly one cycle.
REQ-033 Assert i_rst_n=0 during WR1 -> WE_N=1, CE_N=1, DQ high-Z same cycle; no o_wr_ack.
REQ-034 Read addr 0xFFFFF, then drop i_rd_req during RD1 -> access completes, o_rd_valid pulses, ADDR=0xFFFFF.
REQ-035 Random 10k mixed requests -> bus-contention checker (REQ-026) never fires; scoreboard matches all reads.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-requester (recorder write / player read) arbiter for an asynchronous 16-bit SRAM.
// Round-robin grant in IDLE, two-cycle write and read accesses, all outputs registered.
`timescale 1ns/1ps
module sram_arbiter (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_wr_req,
   input  logic [19:0] i_wr_addr,
   input  logic [15:0] i_wr_data,
   output logic        o_wr_ack,
   input  logic        i_rd_req,
   input  logic [19:0] i_rd_addr,
   output logic        o_rd_valid,
   output logic [15:0] o_rd_data,
   output logic        o_busy,
   output logic [19:0] o_SRAM_ADDR,
   inout  wire  [15:0] io_SRAM_DQ,
   output logic        o_SRAM_WE_N,
   output logic        o_SRAM_CE_N,
   output logic        o_SRAM_OE_N,
   output logic        o_SRAM_LB_N,
   output logic        o_SRAM_UB_N
);

   localparam int unsigned AW = 20;
   localparam int unsigned DW = 16;

   typedef enum logic [2:0] {IDLE, WR1, WR2, RD1, RD2} state_t;

   state_t          state, state_nx;
   logic            rd_next, rd_next_nx;
   logic [AW-1:0]   addr_nx;
   logic [DW-1:0]   wdata, wdata_nx;
   logic            dq_oe, dq_oe_nx;
   logic [DW-1:0]   rd_data_nx;
   logic            wr_ack_nx, rd_valid_nx, busy_nx;
   logic            ce_n_nx, we_n_nx, oe_n_nx;

   // DQ is only driven during the two write states, so it can never overlap OE_N=0.
   assign io_SRAM_DQ = dq_oe ? wdata : {DW{1'bz}};

   // Next-state, grant and next-output logic; controls are derived from the next state.
   always_comb begin
      state_nx   = state;
      rd_next_nx = rd_next;
      addr_nx    = o_SRAM_ADDR;
      wdata_nx   = wdata;
      case (state)
         IDLE: begin
            if (i_wr_req && (!i_rd_req || !rd_next)) begin
               state_nx   = WR1;
               addr_nx    = i_wr_addr;
               wdata_nx   = i_wr_data;
               rd_next_nx = 1'b1;
            end else if (i_rd_req) begin
               state_nx   = RD1;
               addr_nx    = i_rd_addr;
               rd_next_nx = 1'b0;
            end
         end
         WR1:     state_nx = WR2;
         WR2:     state_nx = IDLE;
         RD1:     state_nx = RD2;
         RD2:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase

      ce_n_nx     = (state_nx == IDLE);
      we_n_nx     = (state_nx != WR1);
      oe_n_nx     = !((state_nx == RD1) || (state_nx == RD2));
      dq_oe_nx    = (state_nx == WR1) || (state_nx == WR2);
      wr_ack_nx   = (state_nx == WR2);
      rd_valid_nx = (state == RD2);
      rd_data_nx  = (state == RD2) ? io_SRAM_DQ : o_rd_data;
      busy_nx     = (state_nx != IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         rd_next     <= 1'b0;
         wdata       <= '0;
         dq_oe       <= 1'b0;
         o_wr_ack    <= 1'b0;
         o_rd_valid  <= 1'b0;
         o_rd_data   <= '0;
         o_busy      <= 1'b0;
         o_SRAM_ADDR <= '0;
         o_SRAM_WE_N <= 1'b1;
         o_SRAM_CE_N <= 1'b1;
         o_SRAM_OE_N <= 1'b1;
         o_SRAM_LB_N <= 1'b1;
         o_SRAM_UB_N <= 1'b1;
      end else begin
         state       <= state_nx;
         rd_next     <= rd_next_nx;
         wdata       <= wdata_nx;
         dq_oe       <= dq_oe_nx;
         o_wr_ack    <= wr_ack_nx;
         o_rd_valid  <= rd_valid_nx;
         o_rd_data   <= rd_data_nx;
         o_busy      <= busy_nx;
         o_SRAM_ADDR <= addr_nx;
         o_SRAM_WE_N <= we_n_nx;
         o_SRAM_CE_N <= ce_n_nx;
         o_SRAM_OE_N <= oe_n_nx;
         o_SRAM_LB_N <= ce_n_nx;
         o_SRAM_UB_N <= ce_n_nx;
      end
   end

endmodule
